// File: rtl/xs_pkg.sv
// Shared definitions for the xs serial family (xsr receiver, xst transmitter):
// state encoding, datapath widths and a small frame-length helper.
package xs_pkg;

  localparam int BRG_W  = 16;
  localparam int DAT_W  = 64;
  localparam int BITS_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2
  } xs_state_t;

  // Index of the final bit of a frame; a length code of 0 means 64 bits,
  // which the 6-bit wrap of (0 - 1) turns into 63 for free.
  function automatic logic [BITS_W-1:0] last_index(input logic [BITS_W-1:0] bits);
    return bits - BITS_W'(1);
  endfunction

endpackage

// File: rtl/xsr_if.sv
// Signal bundle around the xsr receiver, shared by the bench and any consumer.
// valid/ack: valid is a level that rises when a frame completes and holds dat/datr;
// a one-clock ack drops it; a completion while valid is still high and unacked sets
// the sticky overrun flag. The serial line itself has no backpressure.
interface xsr_if;
  import xs_pkg::*;

  logic              rxd;
  logic [BITS_W-1:0] bits;
  logic [BRG_W-1:0]  rxbaud;
  logic              ack;
  logic [DAT_W-1:0]  dat;
  logic [DAT_W-1:0]  datr;
  logic              valid;
  logic              overrun;
  logic              idle;
  logic [BRG_W-1:0]  brg;
  xs_state_t         state;

  modport master (
    output rxd, bits, rxbaud, ack,
    input  dat, datr, valid, overrun, idle, brg, state
  );

  modport slave (
    input  rxd, bits, rxbaud, ack,
    output dat, datr, valid, overrun, idle, brg, state
  );

endinterface

// File: rtl/xs_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle
// (high) level so a reset never looks like a start edge.
module xs_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      meta_q <= 1'b1;
      q      <= 1'b1;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/xsr.sv
// Serial receiver: detects a falling start edge, samples mid-bit with a reloadable
// bit timer and delivers each frame LSB-first on dat_o and bit-reversed on datr_o.
module xsr
  import xs_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              rxd_i,
  input  logic [BITS_W-1:0] bits_i,
  input  logic [BRG_W-1:0]  rxbaud_i,
  input  logic              ack_i,
  output logic [DAT_W-1:0]  dat_o,
  output logic [DAT_W-1:0]  datr_o,
  output logic              valid_o,
  output logic              overrun_o,
  output logic              idle_o,
  output logic [BRG_W-1:0]  brg_o,
  output xs_state_t         state_o
);

  logic              rxd_s;
  logic              rxd_p;
  xs_state_t         state_q;
  xs_state_t         state_n;
  logic [BITS_W-1:0] bits_q;
  logic [BRG_W-1:0]  baud_q;
  logic [BRG_W-1:0]  brg_q;
  logic [BITS_W-1:0] cnt_q;
  logic [DAT_W-1:0]  work_q;
  logic [DAT_W-1:0]  workr_q;
  logic [DAT_W-1:0]  work_n;
  logic [DAT_W-1:0]  workr_n;

  logic start_edge;
  logic sample;
  logic wr_en;
  logic wr_bit;
  logic complete;

  xs_sync u_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d       (rxd_i),
    .q       (rxd_s)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) rxd_p <= 1'b1;
    else         rxd_p <= rxd_s;
  end

  assign start_edge = rxd_p & ~rxd_s;
  assign sample     = (state_q != ST_IDLE) && (brg_q == '0);

  always_comb begin
    state_n  = state_q;
    wr_en    = 1'b0;
    wr_bit   = 1'b0;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) state_n = ST_START;
      end
      ST_START: begin
        if (sample) begin
          if (rxd_s) begin
            state_n = ST_IDLE;
          end else begin
            wr_en = 1'b1;
            if (bits_q == BITS_W'(1)) complete = 1'b1;
            else                      state_n  = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (sample) begin
          wr_en  = 1'b1;
          wr_bit = rxd_s;
          if (cnt_q == last_index(bits_q)) complete = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (complete) state_n = ST_IDLE;
  end

  // The bit being sampled is merged here so completion can publish it directly.
  // For a 6-bit index, 63 - cnt is simply ~cnt.
  always_comb begin
    work_n  = work_q;
    workr_n = workr_q;
    if (wr_en) begin
      work_n[cnt_q]   = wr_bit;
      workr_n[~cnt_q] = wr_bit;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_n;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bits_q  <= '0;
      baud_q  <= '0;
      brg_q   <= '0;
      cnt_q   <= '0;
      work_q  <= '0;
      workr_q <= '0;
    end else if (state_q == ST_IDLE) begin
      if (start_edge) begin
        bits_q  <= bits_i;
        baud_q  <= rxbaud_i;
        brg_q   <= rxbaud_i >> 1;
        cnt_q   <= '0;
        work_q  <= '0;
        workr_q <= '0;
      end
    end else begin
      if (!sample)                 brg_q <= brg_q - BRG_W'(1);
      else if (state_n == ST_IDLE) brg_q <= '0;
      else                         brg_q <= baud_q;
      if (wr_en) begin
        work_q  <= work_n;
        workr_q <= workr_n;
        cnt_q   <= cnt_q + BITS_W'(1);
      end
    end
  end

  // A simultaneous ack is absorbed by the completing frame: valid stays high.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      dat_o     <= '0;
      datr_o    <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else if (complete) begin
      dat_o   <= work_n;
      datr_o  <= workr_n;
      valid_o <= 1'b1;
      if (valid_o && !ack_i) overrun_o <= 1'b1;
    end else if (ack_i) begin
      valid_o <= 1'b0;
    end
  end

  assign idle_o  = (state_q == ST_IDLE);
  assign brg_o   = brg_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_xsr.sv
// Self-checking bench for xsr: reset values, a vector table of whole frames,
// hand-written corner sequences and randomized frames against a frame-level model.
module tb_xsr;
  import xs_pkg::*;

  logic clk;
  logic rst;
  logic abort_tx;
  int   checks;
  int   failures;
  logic [63:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  xsr_if u_if ();

  xsr u_dut (
    .clk_i     (clk),
    .reset_i   (rst),
    .rxd_i     (u_if.rxd),
    .bits_i    (u_if.bits),
    .rxbaud_i  (u_if.rxbaud),
    .ack_i     (u_if.ack),
    .dat_o     (u_if.dat),
    .datr_o    (u_if.datr),
    .valid_o   (u_if.valid),
    .overrun_o (u_if.overrun),
    .idle_o    (u_if.idle),
    .brg_o     (u_if.brg),
    .state_o   (u_if.state)
  );

  typedef struct {
    int          n;
    int          baud;
    logic [63:0] frame;
    bit          ack_before;
    logic [63:0] exp_dat;
    logic [63:0] exp_datr;
    bit          exp_ovr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] frame_mask(input int n);
    if (n == 0) return '1;
    return (64'd1 << n) - 64'd1;
  endfunction

  function automatic logic [63:0] bit_rev(input logic [63:0] v);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[63-i] = v[i];
    return r;
  endfunction

  task automatic do_reset();
    rst         = 1'b1;
    abort_tx    = 1'b0;
    u_if.rxd    = 1'b1;
    u_if.ack    = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    u_if.ack = 1'b1;
    @(negedge clk);
    u_if.ack = 1'b0;
    #1;
  endtask

  // Drives one frame of n bits (0 = 64) LSB first, (baud+1) clocks per bit, then idle high.
  // Frame settings are scrambled after the start bit to show they are latched.
  task automatic send_frame(input int n, input int baud, input logic [63:0] val);
    int nb;
    nb = (n == 0) ? 64 : n;
    u_if.bits   = n[5:0];
    u_if.rxbaud = baud[15:0];
    for (int i = 0; i < nb; i++) begin
      u_if.rxd = val[i];
      for (int k = 0; k <= baud; k++) begin
        if (abort_tx) begin
          u_if.rxd = 1'b1;
          return;
        end
        tick();
      end
      if (i == 0) begin
        u_if.bits   = 6'($urandom);
        u_if.rxbaud = 16'($urandom_range(1, 40));
      end
    end
    u_if.rxd = 1'b1;
    repeat (2 * baud + 8) tick();
  endtask

  // Returns at the negedge just before the n-th sample clock edge.
  task automatic wait_samples(input int n, output bit ok);
    int seen;
    seen = 0;
    for (int c = 0; c < 20000 && seen < n; c++) begin
      @(negedge clk);
      if (!u_if.idle && u_if.brg == 16'd0) seen++;
    end
    ok = (seen == n);
  endtask

  initial begin
    bit          ok;
    bit          exp_valid;
    bit          exp_ovr;
    bit          saw_busy;
    int          falls;
    logic        prev_idle;
    logic [63:0] v;
    logic [63:0] e;
    int          n;
    int          baud;

    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    abort_tx    = 1'b0;
    u_if.rxd    = 1'b1;
    u_if.ack    = 1'b0;
    u_if.bits   = 6'd11;
    u_if.rxbaud = 16'd4;

    vecs[0] = '{11, 4, 64'h622, 1'b0, 64'h622, 64'h4460_0000_0000_0000, 1'b0};
    vecs[1] = '{11, 4, 64'h7FE, 1'b0, 64'h7FE, 64'h7FE0_0000_0000_0000, 1'b1};
    vecs[2] = '{1,  4, 64'h0,   1'b1, 64'h0,   64'h0,                   1'b1};
    vecs[3] = '{2,  7, 64'h2,   1'b1, 64'h2,   64'h4000_0000_0000_0000, 1'b1};
    vecs[4] = '{8,  5, 64'hAA,  1'b1, 64'hAA,  64'h5500_0000_0000_0000, 1'b1};
    vecs[5] = '{0,  6, 64'hA5A5_0000_FFFF_1230, 1'b1,
                64'hA5A5_0000_FFFF_1230, 64'h0C48_FFFF_0000_A5A5, 1'b1};

    // Reset values
    repeat (2) tick();
    check("rst_dat", u_if.dat, 64'h0);
    check("rst_datr", u_if.datr, 64'h0);
    check("rst_valid", 64'(u_if.valid), 64'h0);
    check("rst_overrun", 64'(u_if.overrun), 64'h0);
    check("rst_idle", 64'(u_if.idle), 64'h1);
    check("rst_brg", 64'(u_if.brg), 64'h0);
    rst = 1'b0;
    repeat (3) tick();

    // False start: two low clocks then high
    u_if.bits   = 6'd11;
    u_if.rxbaud = 16'd4;
    u_if.rxd    = 1'b0;
    repeat (2) tick();
    u_if.rxd = 1'b1;
    saw_busy = 1'b0;
    ok       = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (!u_if.idle) saw_busy = 1'b1;
      if (saw_busy && u_if.idle && !ok) begin
        ok = 1'b1;
        check("false_start_latency", 64'(c <= 6), 64'h1);
      end
    end
    check("false_start_busy", 64'(saw_busy), 64'h1);
    check("false_start_idle", 64'(ok), 64'h1);
    check("false_start_valid", 64'(u_if.valid), 64'h0);
    check("false_start_dat", u_if.dat, 64'h0);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].ack_before) ack_pulse();
      send_frame(vecs[i].n, vecs[i].baud, vecs[i].frame);
      check($sformatf("vec%0d_dat", i), u_if.dat, vecs[i].exp_dat);
      check($sformatf("vec%0d_datr", i), u_if.datr, vecs[i].exp_datr);
      check($sformatf("vec%0d_valid", i), 64'(u_if.valid), 64'h1);
      check($sformatf("vec%0d_overrun", i), 64'(u_if.overrun), 64'(vecs[i].exp_ovr));
      check($sformatf("vec%0d_idle", i), 64'(u_if.idle), 64'h1);
      if (i == 1) begin
        ack_pulse();
        check("ack_clears_valid", 64'(u_if.valid), 64'h0);
        check("ack_keeps_overrun", 64'(u_if.overrun), 64'h1);
      end
    end

    // Ack on the completion clock with valid already high
    do_reset();
    send_frame(11, 4, 64'h622);
    check("pre_sim_valid", 64'(u_if.valid), 64'h1);
    fork
      send_frame(11, 4, 64'h7FE);
      begin
        wait_samples(11, ok);
        u_if.ack = 1'b1;
        @(negedge clk);
        u_if.ack = 1'b0;
      end
    join
    check("sim_wait", 64'(ok), 64'h1);
    check("sim_valid", 64'(u_if.valid), 64'h1);
    check("sim_overrun", 64'(u_if.overrun), 64'h0);
    check("sim_dat", u_if.dat, 64'h7FE);

    // Line held low after completion must not retrigger
    ack_pulse();
    u_if.bits   = 6'd3;
    u_if.rxbaud = 16'd4;
    u_if.rxd    = 1'b0;
    falls     = 0;
    prev_idle = u_if.idle;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (prev_idle && !u_if.idle) falls++;
      prev_idle = u_if.idle;
    end
    check("low_hold_starts", 64'(falls), 64'd1);
    check("low_hold_dat", u_if.dat, 64'h0);
    check("low_hold_idle", 64'(u_if.idle), 64'h1);
    u_if.rxd = 1'b1;
    repeat (6) tick();

    // Reset after the 5th sample abandons the frame
    do_reset();
    fork
      send_frame(11, 4, 64'h7FE);
      begin
        wait_samples(5, ok);
        @(negedge clk);
        abort_tx = 1'b1;
        rst      = 1'b1;
      end
    join
    #2;
    check("midrst_wait", 64'(ok), 64'h1);
    check("midrst_dat", u_if.dat, 64'h0);
    check("midrst_datr", u_if.datr, 64'h0);
    check("midrst_valid", 64'(u_if.valid), 64'h0);
    check("midrst_overrun", 64'(u_if.overrun), 64'h0);
    check("midrst_idle", 64'(u_if.idle), 64'h1);
    check("midrst_brg", 64'(u_if.brg), 64'h0);
    repeat (2) tick();
    rst      = 1'b0;
    abort_tx = 1'b0;
    send_frame(11, 4, 64'h622);
    check("postrst_dat", u_if.dat, 64'h622);
    check("postrst_datr", u_if.datr, 64'h4460_0000_0000_0000);
    check("postrst_valid", 64'(u_if.valid), 64'h1);

    // Randomized frames against the frame-level model
    do_reset();
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    for (int r = 0; r < 12; r++) begin
      n    = $urandom_range(0, 63);
      baud = $urandom_range(3, 12);
      v    = {$urandom, $urandom};
      v    = v & frame_mask(n) & ~64'h1;
      if ($urandom_range(0, 1) == 1) begin
        ack_pulse();
        exp_valid = 1'b0;
      end
      if (exp_valid) exp_ovr = 1'b1;
      exp_valid = 1'b1;
      exp_q.push_back(v);
      send_frame(n, baud, v);
      e = exp_q.pop_front();
      check($sformatf("rnd%0d_dat", r), u_if.dat, e);
      check($sformatf("rnd%0d_datr", r), u_if.datr, bit_rev(e));
      check($sformatf("rnd%0d_valid", r), 64'(u_if.valid), 64'(exp_valid));
      check($sformatf("rnd%0d_overrun", r), 64'(u_if.overrun), 64'(exp_ovr));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xsr.md
XSR -- requirements
Module: xsr

Interface
REQ-001 clk_i  input  1  single system clock; all state changes on its rising edge.
REQ-002 reset_i  input  1  asynchronous, active-high reset.
REQ-003 rxd_i  input  1  serial line, idle high, LSB-first; may be asynchronous to clk_i.
REQ-004 bits_i  input  6  frame length in bits, start bit included; 0 means 64.
REQ-005 rxbaud_i  input  16  bit period minus one, in clk_i cycles (4 -> 5 clocks/bit, matching xst txbaud_i).
REQ-006 ack_i  input  1  consumer acknowledge; clears valid_o.
REQ-007 dat_o  output  64  last frame, first-received bit at [0], unused upper bits 0.
REQ-008 datr_o  output  64  last frame, first-received bit at [63], unused lower bits 0.
REQ-009 valid_o  output  1  level; a completed frame is held on dat_o/datr_o.
REQ-010 overrun_o  output  1  sticky; a frame completed while valid_o was still set.
REQ-011 idle_o  output  1  high when no frame is in progress.
REQ-012 brg_o  output  16  current bit-timer value, for test visibility.

Function
REQ-013 rxd_i shall pass through a two-flop synchronizer; rxd_s is its output, and rxd_p is rxd_s delayed one clock.
REQ-014 States shall be IDLE, START and DATA; idle_o = (state == IDLE).
REQ-015 IDLE: when rxd_p=1 and rxd_s=0, the block shall latch bits_i to bits_q and rxbaud_i to baud_q, set brg to rxbaud_i>>1, clear the work registers, set cnt=0 and enter START.
REQ-016 In START and DATA, brg shall decrement by 1 per clock while nonzero; a sample event occurs on the clock where brg==0.
REQ-017 START sample with rxd_s=1 (false start): the block shall return to IDLE with no change to outputs.
REQ-018 START sample with rxd_s=0: the block shall write 0 to work[cnt] and workr[63-cnt], set cnt=1 and brg=baud_q, and enter DATA; if bits_q==1 the frame completes instead.
REQ-019 DATA sample: the block shall write rxd_s to work[cnt] and workr[63-cnt], increment cnt and load brg=baud_q.
REQ-020 When a DATA sample writes index cnt == bits_q-1 (63 when bits_q==0), the frame completes.
REQ-021 Completion: dat_o/datr_o shall load the work registers, including the bit just sampled; valid_o<=1; state<=IDLE; brg<=0.
REQ-022 Completion while valid_o=1 and ack_i=0 shall set overrun_o=1; the new data still overwrites dat_o/datr_o.
REQ-023 ack_i=1 without completion shall clear valid_o next clock; simultaneous ack_i and completion shall leave valid_o=1 with no overrun.
REQ-024 overrun_o shall clear only on reset.
REQ-025 Changes to bits_i and rxbaud_i mid-frame shall have no effect until the next start edge.
REQ-026 In IDLE, brg shall hold 0.
REQ-027 A start edge requires rxd_s high in the previous cycle; a line held low after completion shall not retrigger.

Reset
REQ-028 reset_i high shall asynchronously force state=IDLE, brg=0, cnt=0, work=workr=0, dat_o=datr_o=0, valid_o=0, overrun_o=0, and both synchronizer flops and rxd_p to 1.
REQ-029 Reset asserted mid-frame shall abandon the frame with no completion; the first start edge after release shall be honoured.

Structure
REQ-030 Shared package xs_pkg shall hold the state encoding, BRG_W=16, DAT_W=64 and BITS_W=6; xst shall use the same package.
REQ-031 The synchronizer shall be a separate sub-module xs_sync (2-flop, reset value 1), with no other sub-modules.

Verification
REQ-032 Loopback from xst (txbaud=4, bits=11, txreg data 11'b11_00010001_0), rxbaud=4, bits=11 -> one completion; dat_o=64'h622; datr_o[63:53]=11'b01000100011, rest 0; valid_o=1; overrun_o=0.
REQ-033 rxd_i low for 2 clocks then high, rxbaud=4 -> idle_o returns to 1 within 6 clocks; valid_o stays 0; dat_o unchanged.
REQ-034 Two back-to-back frames (0x622, then 0x7FE) with no ack -> overrun_o=1, dat_o=64'h7FE; ack pulse -> valid_o=0, overrun_o stays 1.
REQ-035 Completion on the same clock as ack_i -> valid_o stays 1, overrun_o=0.
REQ-036 Reset pulse after the 5th bit sample -> all outputs at reset values; a following full frame is received correctly.
REQ-037 bits_i=0, 64-bit pattern 64'hA5A5_0000_FFFF_1230 (bit 0 = 0 as the start bit) -> dat_o equals the pattern and datr_o equals its bit-reverse.
